// File: rtl/arb_burst_mem_slave_if.sv
// +--------------------------------------------------------------------------+
// | arb_burst_mem_slave_if : arbiter burst bus between initiator and memory   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface arb_burst_mem_slave_if;
  logic [31:0] arb_address;
  logic [3:0]  arb_byteEnable;
  logic        arb_read;
  logic        arb_write;
  logic [31:0] arb_writeData;
  logic        arb_waitRequest;
  logic        arb_beginBurstTransfer;
  logic [7:0]  arb_burstCount;
  logic [31:0] arb_readData;
  logic        arb_readDataValid;

  modport master (
    output arb_address, arb_byteEnable, arb_read, arb_write, arb_writeData,
           arb_beginBurstTransfer, arb_burstCount,
    input  arb_waitRequest, arb_readData, arb_readDataValid
  );

  modport slave (
    input  arb_address, arb_byteEnable, arb_read, arb_write, arb_writeData,
           arb_beginBurstTransfer, arb_burstCount,
    output arb_waitRequest, arb_readData, arb_readDataValid
  );
endinterface

`default_nettype wire

// File: rtl/arb_burst_mem_slave.sv
// +--------------------------------------------------------------------------+
// | arb_burst_mem_slave : burst word memory responder on the arbiter bus.     |
// | Optional macro WAIT_INJECT_EN adds LFSR-driven waitRequest stalls.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module arb_burst_mem_slave #(
  parameter int MEM_SIZE     = 65536,
  parameter int READ_LATENCY = 2
) (
  input  wire logic            clk,
  input  wire logic            rest,
  arb_burst_mem_slave_if.slave arb
);

  localparam int DEPTH  = MEM_SIZE / 4;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_LAT   = 2'd1,
    RD_DATA  = 2'd2,
    WR_BURST = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_waitReq;
  logic [ADDR_W-1:0]   r_beatAddr;
  logic [7:0]          r_remaining;
  logic [3:0]          r_latCnt;
  logic [31:0]         r_readData;
  logic                r_readDataValid;
  logic [31:0]         r_mem [DEPTH];

  logic [ADDR_W-1:0]   w_cmdIdx;
  logic [ADDR_W-1:0]   w_wrIdx;
  logic                w_inject;
  logic                w_idleWrite;
  logic                w_idleRead;
  logic                w_burstWrite;
  logic                w_wrEn;
  logic                w_present;
  logic                w_lastBeat;
  logic                w_unusedBits;

`ifdef WAIT_INJECT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Read timing is never disturbed; only command/write-beat acceptance stalls.
  assign w_inject = (r_lfsr[1:0] == 2'b00) && ((r_state == IDLE) || (r_state == WR_BURST));
`else
  assign w_inject = 1'b0;
`endif

  assign arb.arb_waitRequest   = r_waitReq | w_inject;
  assign arb.arb_readData      = r_readData;
  assign arb.arb_readDataValid = r_readDataValid;

  assign w_cmdIdx     = arb.arb_address[ADDR_W+1:2];
  // Write wins when read and write are both raised in IDLE.
  assign w_idleWrite  = (r_state == IDLE) && !arb.arb_waitRequest && arb.arb_write;
  assign w_idleRead   = (r_state == IDLE) && !arb.arb_waitRequest && arb.arb_read && !arb.arb_write;
  assign w_burstWrite = (r_state == WR_BURST) && !arb.arb_waitRequest && arb.arb_write;
  assign w_wrEn       = w_idleWrite | w_burstWrite;
  assign w_wrIdx      = w_idleWrite ? w_cmdIdx : r_beatAddr;
  assign w_present    = ((r_state == RD_LAT) && (r_latCnt == 4'd0)) || (r_state == RD_DATA);
  assign w_lastBeat   = (r_remaining <= 8'd1);

  assign w_unusedBits = ^{arb.arb_beginBurstTransfer, arb.arb_address[31:ADDR_W+2],
                          arb.arb_address[1:0]};

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (arb.arb_byteEnable[i]) begin
          r_mem[w_wrIdx][8*i +: 8] <= arb.arb_writeData[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state         <= IDLE;
      r_waitReq       <= 1'b1;
      r_beatAddr      <= '0;
      r_remaining     <= 8'd0;
      r_latCnt        <= 4'd0;
      r_readData      <= 32'd0;
      r_readDataValid <= 1'b0;
    end else begin
      r_readDataValid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_waitReq <= 1'b0;
          if (w_idleWrite) begin
            if (arb.arb_burstCount > 8'd1) begin
              r_state     <= WR_BURST;
              r_beatAddr  <= w_cmdIdx + 1'b1;
              r_remaining <= arb.arb_burstCount - 8'd1;
            end
          end else if (w_idleRead) begin
            r_state     <= RD_LAT;
            r_waitReq   <= 1'b1;
            r_beatAddr  <= w_cmdIdx;
            r_remaining <= (arb.arb_burstCount == 8'd0) ? 8'd1 : arb.arb_burstCount;
            r_latCnt    <= 4'(READ_LATENCY - 1);
          end
        end
        RD_LAT: begin
          if (r_latCnt != 4'd0) begin
            r_latCnt <= r_latCnt - 4'd1;
          end
        end
        RD_DATA: begin
        end
        WR_BURST: begin
          if (w_burstWrite) begin
            r_beatAddr  <= r_beatAddr + 1'b1;
            r_remaining <= r_remaining - 8'd1;
            if (w_lastBeat) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // The latency count expiring presents beat 0 on the same edge.
      if (w_present) begin
        r_readData      <= r_mem[r_beatAddr];
        r_readDataValid <= 1'b1;
        r_beatAddr      <= r_beatAddr + 1'b1;
        r_remaining     <= r_remaining - 8'd1;
        if (w_lastBeat) begin
          r_state   <= IDLE;
          r_waitReq <= 1'b0;
        end else begin
          r_state   <= RD_DATA;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_burst_mem_slave.sv
// +--------------------------------------------------------------------------+
// | tb_arb_burst_mem_slave : directed and scoreboard bench for the responder. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_arb_burst_mem_slave;

  localparam int MEM_SIZE = 65536;
  localparam int DEPTH    = MEM_SIZE / 4;

  logic clk;
  logic rest;
  int   checks;
  int   errors;
  bit   sawStall;

  arb_burst_mem_slave_if bus ();

  arb_burst_mem_slave #(.MEM_SIZE(MEM_SIZE), .READ_LATENCY(2)) dut (
    .clk  (clk),
    .rest (rest),
    .arb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wrBurst(input logic [31:0] addr, input int n, input logic [31:0] d[$],
                         input logic [3:0] be[$], input int dropAt, input int dropCyc);
    int beat;
    int cyc;
    int dropLeft;
    int nb;
    bit acc;
    beat = 0; cyc = 0; dropLeft = dropCyc;
    nb = (n == 0) ? 1 : n;
    while (beat < nb && cyc < 300) begin
      @(negedge clk);
      cyc++;
      acc = 1'b0;
      if (beat == dropAt && dropLeft > 0) begin
        bus.arb_write = 1'b0;
        dropLeft--;
      end else begin
        bus.arb_write              = 1'b1;
        bus.arb_address            = addr;
        bus.arb_burstCount         = 8'(n);
        bus.arb_writeData          = d[beat];
        bus.arb_byteEnable         = be[beat];
        bus.arb_beginBurstTransfer = (beat == 0);
        acc = !bus.arb_waitRequest;
        if (!acc && beat == 0) sawStall = 1'b1;
      end
      @(posedge clk);
      if (acc) beat++;
    end
    @(negedge clk);
    bus.arb_write = 1'b0;
    bus.arb_beginBurstTransfer = 1'b0;
    if (beat < nb) begin
      checks++; errors++;
      $display("FAIL wr_timeout addr=%h beats_done=%0d required=%0d", addr, beat, nb);
    end
  endtask

  task automatic rdBurst(input logic [31:0] addr, input int n, output logic [31:0] q[$],
                         output int lat, output bit waitOk, output bit gapless, output int extra);
    int nb;
    int cyc;
    int k;
    bit acc;
    q = {}; lat = -1; waitOk = 1'b1; gapless = 1'b0; extra = 0;
    nb = (n == 0) ? 1 : n;
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.arb_read       = 1'b1;
      bus.arb_address    = addr;
      bus.arb_burstCount = 8'(n);
      acc = !bus.arb_waitRequest;
      if (!acc) sawStall = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.arb_read = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL rd_accept_timeout addr=%h", addr);
      return;
    end
    k = 0;
    while (q.size() < nb && k < 100) begin
      if (bus.arb_readDataValid) begin
        if (lat < 0) lat = k;
        q.push_back(bus.arb_readData);
        if (q.size() < nb) begin
          if (bus.arb_waitRequest !== 1'b1) waitOk = 1'b0;
        end else begin
`ifndef WAIT_INJECT_EN
          if (bus.arb_waitRequest !== 1'b0) waitOk = 1'b0;
`endif
        end
      end else if (bus.arb_waitRequest !== 1'b1) begin
        waitOk = 1'b0;
      end
      if (q.size() < nb) begin
        @(negedge clk);
        k++;
      end
    end
    gapless = (q.size() == nb) && (k - lat + 1 == nb);
    if (q.size() < nb) begin
      checks++; errors++;
      $display("FAIL rd_data_timeout addr=%h beats=%0d required=%0d", addr, q.size(), nb);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.arb_readDataValid) extra++;
    end
  endtask

  task automatic test_reset();
    rest = 1'b0;
    bus.arb_address = '0; bus.arb_byteEnable = '0; bus.arb_read = 1'b0;
    bus.arb_write = 1'b0; bus.arb_writeData = '0; bus.arb_beginBurstTransfer = 1'b0;
    bus.arb_burstCount = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.arb_waitRequest !== 1'b1) begin errors++; $display("FAIL reset_wait got=%b exp=1", bus.arb_waitRequest); end
    checks++;
    if (bus.arb_readDataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.arb_readDataValid); end
    checks++;
    if (bus.arb_readData !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.arb_readData); end
    rest = 1'b1;
    #1;
    checks++;
    if (bus.arb_waitRequest !== 1'b1) begin errors++; $display("FAIL release_wait_pre_edge got=%b exp=1", bus.arb_waitRequest); end
    @(negedge clk);
    checks++;
    if (bus.arb_waitRequest !== 1'b0) begin errors++; $display("FAIL release_wait_post_edge got=%b exp=0", bus.arb_waitRequest); end
  endtask

  task automatic test_single();
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    int lat, extra;
    bit wOk, gl;
    d.push_back(32'hDEADBEEF); b.push_back(4'hF);
    wrBurst(32'h100, 1, d, b, -1, 0);
    rdBurst(32'h100, 1, q, lat, wOk, gl, extra);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", lat); end
    checks++;
    if (q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", q[0]); end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL single_extra_beats got=%0d exp=0", extra); end
  endtask

  task automatic test_burst();
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    int lat, extra;
    bit wOk, gl;
    for (int i = 0; i < 8; i++) begin d.push_back(32'(i)); b.push_back(4'hF); end
    wrBurst(32'h200, 8, d, b, 3, 2);
    rdBurst(32'h200, 8, q, lat, wOk, gl, extra);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q[i] !== 32'(i)) begin errors++; $display("FAIL burst_beat%0d got=%h exp=%h", i, q[i], i); end
    end
    checks++;
    if (!gl) begin errors++; $display("FAIL burst_gapless got=0 exp=1"); end
    checks++;
    if (!wOk) begin errors++; $display("FAIL burst_wait_window got=0 exp=1"); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL burst_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_partial();
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    int lat, extra;
    bit wOk, gl;
    d = {}; b = {}; d.push_back(32'hFFFFFFFF); b.push_back(4'hF);
    wrBurst(32'h300, 1, d, b, -1, 0);
    d = {}; b = {}; d.push_back(32'h11223344); b.push_back(4'b0101);
    wrBurst(32'h300, 1, d, b, -1, 0);
    rdBurst(32'h300, 1, q, lat, wOk, gl, extra);
    checks++;
    if (q[0] !== 32'hFF22FF44) begin errors++; $display("FAIL partial_lanes got=%h exp=ff22ff44", q[0]); end
    d = {}; b = {}; d.push_back(32'h00000000); b.push_back(4'b0000);
    wrBurst(32'h300, 1, d, b, -1, 0);
    rdBurst(32'h300, 1, q, lat, wOk, gl, extra);
    checks++;
    if (q[0] !== 32'hFF22FF44) begin errors++; $display("FAIL partial_be0 got=%h exp=ff22ff44", q[0]); end
  endtask

  task automatic test_wrap();
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    logic [31:0] exp4[4];
    int lat, extra;
    bit wOk, gl;
    exp4[0] = 32'hA0A0A0A0; exp4[1] = 32'hA1A1A1A1; exp4[2] = 32'hA2A2A2A2; exp4[3] = 32'hA3A3A3A3;
    for (int i = 0; i < 4; i++) begin d.push_back(exp4[i]); b.push_back(4'hF); end
    wrBurst(32'(MEM_SIZE - 8), 4, d, b, -1, 0);
    rdBurst(32'(MEM_SIZE - 8), 4, q, lat, wOk, gl, extra);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i] !== exp4[i]) begin errors++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, q[i], exp4[i]); end
    end
    rdBurst(32'h0, 2, q, lat, wOk, gl, extra);
    checks++;
    if (q[0] !== exp4[2] || q[1] !== exp4[3]) begin
      errors++; $display("FAIL wrap_word0 got=%h,%h exp=%h,%h", q[0], q[1], exp4[2], exp4[3]);
    end
    d = {}; b = {}; d.push_back(32'h5A5A1234); b.push_back(4'hF);
    wrBurst(32'h10, 1, d, b, -1, 0);
    rdBurst(32'(MEM_SIZE + 16), 1, q, lat, wOk, gl, extra);
    checks++;
    if (q[0] !== 32'h5A5A1234) begin errors++; $display("FAIL alias got=%h exp=5a5a1234", q[0]); end
    rdBurst(32'h10, 0, q, lat, wOk, gl, extra);
    checks++;
    if (q.size() !== 1 || extra !== 0 || q[0] !== 32'h5A5A1234) begin
      errors++; $display("FAIL count0 beats=%0d extra=%0d data=%h exp=1,0,5a5a1234", q.size(), extra, q[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    int lat, extra, seen, cyc;
    bit wOk, gl, acc;
    for (int i = 0; i < 16; i++) begin d.push_back(32'h1000 + 32'(i)); b.push_back(4'hF); end
    wrBurst(32'h400, 16, d, b, -1, 0);
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.arb_read = 1'b1; bus.arb_address = 32'h400; bus.arb_burstCount = 8'd16;
      acc = !bus.arb_waitRequest;
      @(posedge clk);
    end
    @(negedge clk);
    bus.arb_read = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 4 && cyc < 50) begin
      if (bus.arb_readDataValid) seen++;
      if (seen < 4) begin @(negedge clk); cyc++; end
    end
    checks++;
    if (seen !== 4) begin errors++; $display("FAIL rstmid_beats_before got=%0d exp=4", seen); end
    #2 rest = 1'b0;
    #1;
    checks++;
    if (bus.arb_readDataValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", bus.arb_readDataValid); end
    checks++;
    if (bus.arb_waitRequest !== 1'b1) begin errors++; $display("FAIL rstmid_wait got=%b exp=1", bus.arb_waitRequest); end
    @(negedge clk);
    rest = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.arb_readDataValid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid got=%b exp=0", bus.arb_readDataValid); end
    rdBurst(32'h400, 16, q, lat, wOk, gl, extra);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL rstmid_mem%0d got=%h exp=%h", i, q[i], 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] refMem[32];
    logic [31:0] d[$];
    logic [3:0]  b[$];
    logic [31:0] q[$];
    int lat, extra, nTr, len, start;
    bit wOk, gl;
    sawStall = 1'b0;
`ifdef WAIT_INJECT_EN
    nTr = 1000;
`else
    nTr = 150;
`endif
    d = {}; b = {};
    for (int i = 0; i < 32; i++) begin
      refMem[i] = $urandom; d.push_back(refMem[i]); b.push_back(4'hF);
    end
    wrBurst(32'h800, 32, d, b, -1, 0);
    for (int t = 0; t < nTr; t++) begin
      len = $urandom_range(1, 4);
      start = $urandom_range(0, 32 - len);
      if ($urandom_range(0, 1) == 1) begin
        d = {}; b = {};
        for (int i = 0; i < len; i++) begin d.push_back($urandom); b.push_back(4'($urandom)); end
        wrBurst(32'h800 + 32'(start * 4), len, d, b, $urandom_range(0, len), 1);
        for (int i = 0; i < len; i++)
          for (int l = 0; l < 4; l++)
            if (b[i][l]) refMem[start + i][8*l +: 8] = d[i][8*l +: 8];
      end else begin
        rdBurst(32'h800 + 32'(start * 4), len, q, lat, wOk, gl, extra);
        for (int i = 0; i < len; i++) begin
          checks++;
          if (q[i] !== refMem[start + i]) begin
            errors++; $display("FAIL rand_t%0d_w%0d got=%h exp=%h", t, start + i, q[i], refMem[start + i]);
          end
        end
      end
    end
`ifdef WAIT_INJECT_EN
    checks++;
    if (sawStall !== 1'b1) begin errors++; $display("FAIL inject_stall_seen got=0 exp=1"); end
`endif
  endtask

  initial begin
    checks = 0; errors = 0; sawStall = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_partial();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
